i2s_rx_array: RTL and testbench

I2S_RX_ARRAY -- requirements
Module: i2s_rx_array

---
 rtl/i2s_rx_array.sv | 88 ++++++++
 tb/tb_i2s_rx_array.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_array.sv
// Multi-line I2S receiver: generates WS from the bit clock, captures a left and a right
// two's-complement sample per data line, and presents whole frames through a valid/ready hold register.
module i2s_rx_array #(
   parameter int NUM_LINES   = 4,
   parameter int SAMPLE_BITS = 8,
   parameter int SLOT_BITS   = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 en,
   input  logic [NUM_LINES-1:0]                 sd_in,
   input  logic                                 overrun_clr,
   input  logic                                 pcm_ready,
   output logic                                 ws_out,
   output logic [2*NUM_LINES*SAMPLE_BITS-1:0]   pcm_out,
   output logic                                 pcm_valid,
   output logic                                 overrun
);

   localparam int POS_W   = $clog2(SLOT_BITS);
   localparam int CNT_W   = POS_W + 1;
   localparam int FRAME_W = 2 * NUM_LINES * SAMPLE_BITS;

   logic [CNT_W-1:0]   cnt;
   logic [POS_W-1:0]   pos;
   logic               ch;
   logic               shift_en;
   logic               frame_done;
   logic               load;
   logic               drop;
   logic [FRAME_W-1:0] shreg;

   assign pos = cnt[POS_W-1:0];
   assign ch  = cnt[POS_W];

   // WS comes straight from a counter flop, so it cannot glitch.
   assign ws_out = ch;

   // Position 0 of each slot is the one-bit I2S delay; bits beyond the sample are padding.
   assign shift_en   = en && (pos != '0) && (int'(pos) <= SAMPLE_BITS);
   assign frame_done = en && (&cnt);
   assign load       = frame_done && (!pcm_valid || pcm_ready);
   assign drop       = frame_done && pcm_valid && !pcm_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Shift registers use the same packing as pcm_out so a frame loads as one copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
      end else if (shift_en) begin
         for (int k = 0; k < NUM_LINES; k++) begin
            shreg[(2*k + int'(ch))*SAMPLE_BITS +: SAMPLE_BITS] <=
               {shreg[(2*k + int'(ch))*SAMPLE_BITS +: SAMPLE_BITS-1], sd_in[k]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcm_out   <= '0;
         pcm_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            pcm_out   <= shreg;
            pcm_valid <= 1'b1;
         end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
         end
         // A dropped frame on the same edge as a clear keeps the flag set.
         if (drop) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_array.sv
// Directed bench for i2s_rx_array with two lines, 8-bit samples and 16-bit slots.
module tb_i2s_rx_array;

   localparam int NL = 2;
   localparam int SB = 8;
   localparam int SL = 16;

   logic              clk;
   logic              rst_n;
   logic              en;
   logic [NL-1:0]     sd_in;
   logic              overrun_clr;
   logic              pcm_ready;
   logic              ws_out;
   logic [2*NL*SB-1:0] pcm_out;
   logic              pcm_valid;
   logic              overrun;
   logic              clk_run;

   int vectors;
   int miscompares;

   i2s_rx_array #(
      .NUM_LINES  (NL),
      .SAMPLE_BITS(SB),
      .SLOT_BITS  (SL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .sd_in      (sd_in),
      .overrun_clr(overrun_clr),
      .pcm_ready  (pcm_ready),
      .ws_out     (ws_out),
      .pcm_out    (pcm_out),
      .pcm_valid  (pcm_valid),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one full 32-edge frame starting from cnt=0; padding and delay bits are driven as 1.
   task automatic send_frame(input logic [7:0] l0, input logic [7:0] r0,
                             input logic [7:0] l1, input logic [7:0] r1,
                             input bit idle_chk, input string tag);
      int pos;
      int b;
      for (int i = 0; i < 2*SL; i++) begin
         pos = i % SL;
         if (pos >= 1 && pos <= SB) begin
            b = SB - pos;
            sd_in[0] = (i >= SL) ? r0[b] : l0[b];
            sd_in[1] = (i >= SL) ? r1[b] : l1[b];
         end else begin
            sd_in = '1;
         end
         tick();
         chk($sformatf("%s_ws%0d", tag, i), 64'(ws_out), 64'((((i + 1) % (2*SL)) >= SL) ? 1 : 0));
         if (idle_chk && i < 2*SL-1) chk($sformatf("%s_idle%0d", tag, i), 64'(pcm_valid), 64'd0);
      end
      sd_in = '0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clk_run     = 1'b1;
      rst_n       = 1'b0;
      en          = 1'b0;
      sd_in       = '0;
      overrun_clr = 1'b0;
      pcm_ready   = 1'b0;
      #2;
      chk("rst_ws", 64'(ws_out), 64'd0);
      chk("rst_valid", 64'(pcm_valid), 64'd0);
      chk("rst_ovr", 64'(overrun), 64'd0);
      chk("rst_pcm", 64'(pcm_out), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // First frame: valid after exactly 32 enabled edges
      en        = 1'b1;
      pcm_ready = 1'b1;
      send_frame(8'hA5, 8'h3C, 8'h80, 8'h7F, 1'b1, "fA");
      chk("fA_valid", 64'(pcm_valid), 64'd1);
      chk("fA_pcm", 64'(pcm_out), 64'h7F803CA5);
      chk("fA_ovr", 64'(overrun), 64'd0);

      // Back-to-back frame with ready held: valid drops after one cycle, no overrun
      send_frame(8'h01, 8'hFE, 8'h55, 8'hAA, 1'b1, "fB");
      chk("fB_valid", 64'(pcm_valid), 64'd1);
      chk("fB_pcm", 64'(pcm_out), 64'hAA55FE01);
      chk("fB_ovr", 64'(overrun), 64'd0);

      // Ready low: frame C is dropped, B is held, overrun sets
      pcm_ready = 1'b0;
      send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, "fC");
      chk("fC_valid", 64'(pcm_valid), 64'd1);
      chk("fC_pcm_held", 64'(pcm_out), 64'hAA55FE01);
      chk("fC_ovr", 64'(overrun), 64'd1);
      pcm_ready = 1'b1;
      tick();
      chk("acc_valid", 64'(pcm_valid), 64'd0);
      chk("acc_ovr_kept", 64'(overrun), 64'd1);
      chk("acc_pcm_kept", 64'(pcm_out), 64'hAA55FE01);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("clr_ovr", 64'(overrun), 64'd0);

      // Re-align with en low, then check that en low forces WS back to left
      en = 1'b0;
      tick();
      chk("en0_ws", 64'(ws_out), 64'd0);
      en = 1'b1;
      repeat (20) tick();
      chk("cnt20_ws", 64'(ws_out), 64'd1);
      en = 1'b0;
      tick();
      chk("en0_ws_forced", 64'(ws_out), 64'd0);

      // Drop en at cnt=10 for three cycles, then a full frame is needed before valid
      en = 1'b1;
      repeat (10) tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("gap_ws%0d", i), 64'(ws_out), 64'd0);
         chk($sformatf("gap_valid%0d", i), 64'(pcm_valid), 64'd0);
      end
      en = 1'b1;
      send_frame(8'h12, 8'h34, 8'hC8, 8'h09, 1'b1, "fE");
      chk("fE_valid", 64'(pcm_valid), 64'd1);
      chk("fE_pcm", 64'(pcm_out), 64'h09C83412);

      // Build up overrun, then assert reset mid-frame with the clock stopped
      pcm_ready = 1'b0;
      send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, "fF");
      chk("fF_pcm_held", 64'(pcm_out), 64'h09C83412);
      chk("fF_ovr", 64'(overrun), 64'd1);
      repeat (20) tick();
      chk("mid_ws", 64'(ws_out), 64'd1);
      clk_run = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ws", 64'(ws_out), 64'd0);
      chk("arst_valid", 64'(pcm_valid), 64'd0);
      chk("arst_ovr", 64'(overrun), 64'd0);
      chk("arst_pcm", 64'(pcm_out), 64'd0);
      #5;
      rst_n = 1'b1;
      #2;
      clk_run   = 1'b1;
      pcm_ready = 1'b1;
      send_frame(8'h7E, 8'h81, 8'h00, 8'hFF, 1'b1, "fG");
      chk("fG_valid", 64'(pcm_valid), 64'd1);
      chk("fG_pcm", 64'(pcm_out), 64'hFF00817E);
      chk("fG_ovr", 64'(overrun), 64'd0);
      tick();
      chk("fG_pulse_end", 64'(pcm_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
